// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory port arbiter.
// Owner encoding is used for both the live grant and the read-return router.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W         = 9;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_STARVE_LIMIT   = 8;
    localparam int DEF_REFRESH_CYCLES = 1024;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of CPU, debug-reader and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding datapath.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = dmem_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = dmem_arb_pkg::DEF_DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_valid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_addr, mem_rdata,
        output cpu_stall, cpu_rdata, cpu_rvalid, dbg_rdata, dbg_valid,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_addr, mem_rdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid, dbg_rdata, dbg_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_refresh_timer.sv
// Debug address change detector plus periodic re-read timer.
// o_dbg_kick pulses for one cycle whenever the debug word must be fetched again.
module dmem_refresh_timer
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [ADDR_W-1:0] o_dbg_addr_q,
    output logic              o_addr_changed,
    output logic              o_dbg_kick
);
    localparam int CNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    logic [CNT_W-1:0]  r_refresh_cnt;
    logic [ADDR_W-1:0] r_dbg_addr_q;
    logic              w_wrap;

    assign o_addr_changed = (i_dbg_addr != r_dbg_addr_q);
    assign w_wrap         = (r_refresh_cnt == CNT_LAST);
    assign o_dbg_kick     = o_addr_changed || w_wrap;
    assign o_dbg_addr_q   = r_dbg_addr_q;

    // A new address restarts the interval so the re-read period counts from the last fetch request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refresh_cnt <= '0;
            r_dbg_addr_q  <= '0;
        end else begin
            r_dbg_addr_q <= i_dbg_addr;
            if (o_dbg_kick) begin
                r_refresh_cnt <= '0;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single data-memory port shared by the MEM stage (priority) and the board debug reader.
// Optional DMEM_DBG_SNOOP_EN: CPU stores to the displayed address update the debug word directly.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    dmem_port_arbiter_if.slave bus
);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    owner_e              r_last_owner, w_last_owner_next, w_winner;
    logic                r_dbg_pending, w_dbg_pending_next;
    logic [STARVE_W-1:0] r_starve_cnt, w_starve_cnt_next;
    logic [DATA_W-1:0]   r_dbg_rdata, w_dbg_rdata_next;
    logic                r_dbg_valid, w_dbg_valid_next;
    logic [ADDR_W-1:0]   w_dbg_addr_q;
    logic                w_addr_changed, w_dbg_kick;
    logic                w_store_hit, w_snoop_hit, w_store_repend;
    logic                w_cpu_rvalid;

    dmem_refresh_timer #(
        .ADDR_W        (ADDR_W),
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk           (clk),
        .reset         (reset),
        .i_dbg_addr    (bus.dbg_addr),
        .o_dbg_addr_q  (w_dbg_addr_q),
        .o_addr_changed(w_addr_changed),
        .o_dbg_kick    (w_dbg_kick)
    );

    // Reset gates the grant so the memory sees no access while reset is held.
    always_comb begin
        w_winner = OWN_NONE;
        if (!reset) begin
            if (r_dbg_pending && (!bus.cpu_req || r_starve_cnt == STARVE_MAX)) begin
                w_winner = OWN_DBG;
            end else if (bus.cpu_req) begin
                w_winner = OWN_CPU;
            end
        end
    end

    assign w_store_hit = (w_winner == OWN_CPU) && bus.cpu_we && (bus.cpu_addr == w_dbg_addr_q);

`ifdef DMEM_DBG_SNOOP_EN
    assign w_snoop_hit    = w_store_hit;
    assign w_store_repend = 1'b0;
`else
    assign w_snoop_hit    = 1'b0;
    assign w_store_repend = w_store_hit;
`endif

    assign bus.mem_en     = (w_winner != OWN_NONE);
    assign bus.mem_we     = (w_winner == OWN_CPU) && bus.cpu_we;
    assign bus.mem_addr   = (w_winner == OWN_DBG) ? bus.dbg_addr : bus.cpu_addr;
    assign bus.mem_wdata  = bus.cpu_wdata;
    assign bus.cpu_stall  = bus.cpu_req && (w_winner == OWN_DBG);
    assign w_cpu_rvalid   = (r_last_owner == OWN_CPU);
    assign bus.cpu_rvalid = w_cpu_rvalid;
    assign bus.cpu_rdata  = w_cpu_rvalid ? bus.mem_rdata : '0;
    assign bus.dbg_rdata  = r_dbg_rdata;
    assign bus.dbg_valid  = r_dbg_valid;

    always_comb begin
        w_last_owner_next  = OWN_NONE;
        w_starve_cnt_next  = r_starve_cnt;
        w_dbg_pending_next = r_dbg_pending;
        w_dbg_rdata_next   = r_dbg_rdata;
        w_dbg_valid_next   = r_dbg_valid;

        if (w_winner == OWN_DBG || (w_winner == OWN_CPU && !bus.cpu_we)) begin
            w_last_owner_next = w_winner;
        end

        if (w_winner == OWN_DBG) begin
            w_starve_cnt_next = '0;
        end else if (r_dbg_pending && w_winner == OWN_CPU && r_starve_cnt != STARVE_MAX) begin
            w_starve_cnt_next = r_starve_cnt + STARVE_W'(1);
        end

        // A set request in the same cycle as the grant keeps the read pending.
        if (w_winner == OWN_DBG) begin
            w_dbg_pending_next = 1'b0;
        end
        if (w_dbg_kick || w_store_repend) begin
            w_dbg_pending_next = 1'b1;
        end

        // Returning words belong to dbg_addr_q; a snooped store is newer than any in-flight read.
        if (w_addr_changed) begin
            w_dbg_valid_next = 1'b0;
        end else begin
            if (r_last_owner == OWN_DBG) begin
                w_dbg_rdata_next = bus.mem_rdata;
                w_dbg_valid_next = 1'b1;
            end
            if (w_snoop_hit) begin
                w_dbg_rdata_next = bus.cpu_wdata;
                w_dbg_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_owner  <= OWN_NONE;
            r_starve_cnt  <= '0;
            r_dbg_pending <= 1'b1;
            r_dbg_rdata   <= '0;
            r_dbg_valid   <= 1'b0;
        end else begin
            r_last_owner  <= w_last_owner_next;
            r_starve_cnt  <= w_starve_cnt_next;
            r_dbg_pending <= w_dbg_pending_next;
            r_dbg_rdata   <= w_dbg_rdata_next;
            r_dbg_valid   <= w_dbg_valid_next;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter against a cycle-level reference of the arbitration rules.
// Build with +define+DMEM_DBG_SNOOP_EN to exercise the store-snoop variant.
module tb_dmem_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int SL = 8;
    localparam int RC = 64;
    localparam int M_NONE = 0;
    localparam int M_CPU  = 1;
    localparam int M_DBG  = 2;
`ifdef DMEM_DBG_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_load = 1'b1;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    dmem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .REFRESH_CYCLES(RC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    // Synchronous memory device with one-cycle read latency.
    logic [DW-1:0] mem      [512];
    logic [DW-1:0] init_mem [512];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_mem[i];
        end else if (bus_if.mem_en) begin
            if (bus_if.mem_we) mem[bus_if.mem_addr] <= bus_if.mem_wdata;
            else               bus_if.mem_rdata <= mem[bus_if.mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, expv, $time);
        end
    endtask

    // Reference state
    logic [DW-1:0] ref_mem [512];
    bit            m_pend, m_dvalid;
    int            m_starve, m_rcnt, m_prev, m_lo;
    logic [DW-1:0] m_ret, m_dword;
    bit            obs_stall, obs_en;

    task automatic model_reset();
        m_pend = 1; m_starve = 0; m_rcnt = 0; m_prev = 0; m_lo = M_NONE;
        m_dword = '0; m_dvalid = 0; m_ret = '0;
    endtask

    task automatic step(input bit req, input bit we, input int addr, input logic [31:0] wdata, input int daddr);
        int w, exp_addr;
        bit exp_we, changed, kick, hit;
        bus_if.cpu_req = req; bus_if.cpu_we = we; bus_if.cpu_addr = AW'(addr);
        bus_if.cpu_wdata = wdata; bus_if.dbg_addr = AW'(daddr);
        @(negedge clk);
        if (m_pend && (!req || m_starve == SL)) w = M_DBG;
        else if (req)                         w = M_CPU;
        else                                  w = M_NONE;
        exp_we   = (w == M_CPU) && we;
        exp_addr = (w == M_DBG) ? daddr : addr;
        obs_stall = bus_if.cpu_stall;
        obs_en    = bus_if.mem_en;
        check_eq("mem_en", bus_if.mem_en, w != M_NONE);
        if (w != M_NONE) begin
            check_eq("mem_we", bus_if.mem_we, exp_we);
            check_eq("mem_addr", bus_if.mem_addr, exp_addr);
        end
        if (exp_we) check_eq("mem_wdata", bus_if.mem_wdata, wdata);
        check_eq("cpu_stall", bus_if.cpu_stall, req && (w == M_DBG));
        check_eq("cpu_rvalid", bus_if.cpu_rvalid, m_lo == M_CPU);
        if (m_lo == M_CPU) check_eq("cpu_rdata", bus_if.cpu_rdata, m_ret);
        check_eq("dbg_valid", bus_if.dbg_valid, m_dvalid);
        check_eq("dbg_rdata", bus_if.dbg_rdata, m_dword);
        $display("cyc %0d req=%0b we=%0b a=%0d wd=%h da=%0d | en=%0b mwe=%0b ma=%0d stall=%0b rv=%0b dv=%0b dd=%h",
                 cyc, req, we, addr, wdata, daddr, bus_if.mem_en, bus_if.mem_we, bus_if.mem_addr,
                 bus_if.cpu_stall, bus_if.cpu_rvalid, bus_if.dbg_valid, bus_if.dbg_rdata);
        changed = (daddr != m_prev);
        kick    = changed || (m_rcnt == RC - 1);
        hit     = (w == M_CPU) && we && (addr == m_prev);
        if (changed) m_dvalid = 0;
        else begin
            if (m_lo == M_DBG)   begin m_dword = m_ret; m_dvalid = 1; end
            if (SNOOP && hit)    begin m_dword = wdata; m_dvalid = 1; end
        end
        m_rcnt = kick ? 0 : m_rcnt + 1;
        if (w == M_DBG) m_starve = 0;
        else if (m_pend && w == M_CPU && m_starve < SL) m_starve++;
        if (kick || (hit && !SNOOP)) m_pend = 1;
        else if (w == M_DBG)         m_pend = 0;
        m_lo = (w == M_DBG) ? M_DBG : ((w == M_CPU && !we) ? M_CPU : M_NONE);
        if (m_lo != M_NONE) m_ret = ref_mem[exp_addr];
        if (exp_we) ref_mem[addr] = wdata;
        m_prev = daddr;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input int daddr);
        for (int k = 0; k < n; k++) step(0, 0, 0, 32'h0, daddr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_stall, stall_at, n_en, rd;
        bit found;
        for (int i = 0; i < 512; i++) begin
            init_mem[i] = $urandom;
        end
        init_mem[5] = 32'h2A;
        init_mem[3] = 32'h11;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_mem[i];

        // Reset state, with a CPU request that must not stall or reach memory.
        bus_if.cpu_req = 1; bus_if.cpu_we = 0; bus_if.cpu_addr = '0;
        bus_if.cpu_wdata = '0; bus_if.dbg_addr = AW'(5);
        repeat (3) @(posedge clk);
        #1;
        mem_load = 0;
        check_eq("rst_mem_en", bus_if.mem_en, 0);
        check_eq("rst_mem_we", bus_if.mem_we, 0);
        check_eq("rst_cpu_stall", bus_if.cpu_stall, 0);
        check_eq("rst_dbg_valid", bus_if.dbg_valid, 0);
        check_eq("rst_dbg_rdata", bus_if.dbg_rdata, 0);
        check_eq("rst_cpu_rvalid", bus_if.cpu_rvalid, 0);
        bus_if.cpu_req = 0;
        reset = 0;
        model_reset();

        // First debug read right after reset.
        idle(2, 5);
        check_eq("tp1_dbg_valid", bus_if.dbg_valid, 1);
        check_eq("tp1_dbg_rdata", bus_if.dbg_rdata, 32'h2A);
        idle(2, 5);

        // Plain CPU load with nothing pending.
        step(1, 0, 3, 32'h0, 5);
        check_eq("tp2_rvalid", bus_if.cpu_rvalid, 1);
        check_eq("tp2_rdata", bus_if.cpu_rdata, 32'h11);
        idle(1, 5);

        // Starvation window under continuous CPU traffic.
        idle(4, 4);
        n_stall = 0; stall_at = -1;
        for (int k = 0; k < 20; k++) begin
            step(1, 0, 16 + (k % 8), 32'h0, 7);
            if (obs_stall) begin n_stall++; stall_at = k; end
        end
        check_eq("tp3_stall_count", n_stall, 1);
        check_eq("tp3_stall_cycle", stall_at, 9);

        // Rapid address toggling never shows a valid word.
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 32'h0, (k % 2 == 0) ? 8 : 9);
            check_eq("tp4_toggle_valid", bus_if.dbg_valid, 0);
        end
        idle(3, 8);
        check_eq("tp4_settle_valid", bus_if.dbg_valid, 1);
        check_eq("tp4_settle_rdata", bus_if.dbg_rdata, ref_mem[8]);

        // CPU store to the displayed address.
        idle(4, 7);
        step(1, 1, 7, 32'h99, 7);
        n_en = 0;
        if (SNOOP) check_eq("tp5_snoop_rdata", bus_if.dbg_rdata, 32'h99);
        for (int k = 0; k < 3; k++) begin
            idle(1, 7);
            if (obs_en) n_en++;
        end
        check_eq("tp5_extra_reads", n_en, SNOOP ? 0 : 1);
        check_eq("tp5_dbg_rdata", bus_if.dbg_rdata, 32'h99);
        check_eq("tp5_dbg_valid", bus_if.dbg_valid, 1);

        // Random traffic.
        rd = 7;
        for (int c = 0; c < 1200; c++) begin
            if ($urandom_range(0, 19) == 0) rd = $urandom_range(0, 15);
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 15), $urandom, rd);
        end

        // Reset in the middle of a debug read.
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            idle(1, 12);
            if (m_lo == M_DBG && m_dvalid) found = 1;
        end
        check_eq("tp6_setup", found, 1);
        bus_if.cpu_req = 1;
        #1 reset = 1;
        #1;
        check_eq("tp6_dbg_valid", bus_if.dbg_valid, 0);
        check_eq("tp6_cpu_rvalid", bus_if.cpu_rvalid, 0);
        check_eq("tp6_mem_en", bus_if.mem_en, 0);
        check_eq("tp6_cpu_stall", bus_if.cpu_stall, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("tp6_hold_rdata", bus_if.dbg_rdata, 0);
        check_eq("tp6_hold_mem_en", bus_if.mem_en, 0);
        reset = 0;
        bus_if.cpu_req = 0;
        model_reset();
        idle(1, 12);
        check_eq("tp6_fresh_read", obs_en, 1);
        idle(3, 12);
        check_eq("tp6_fresh_valid", bus_if.dbg_valid, 1);
        check_eq("tp6_fresh_rdata", bus_if.dbg_rdata, ref_mem[12]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
